scoreboard_hazard_unit: RTL

SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

---
 rtl/cpu_types_pkg.sv | 21 ++
 rtl/sb_entry.sv | 37 +++
 rtl/scoreboard_hazard_unit.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register selectors, machine words and the hazard-unit
// redirect FSM states.
package cpu_types_pkg;

    localparam int REG_W  = 5;
    localparam int WORD_W = 32;

    typedef logic [REG_W-1:0]  regbits_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    // Increment that sticks at all ones instead of wrapping.
    function automatic word_t sat_inc(input word_t value);
        return (value == '1) ? value : value + word_t'(1);
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard countdown: loads a producer latency, counts down while the
// pipeline advances and freezes while it is stalled on memory.
module sb_entry #(
    parameter int LAT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [LAT_W-1:0] load_val_i,
    input  logic             hold_i,
    output logic [LAT_W-1:0] cnt_o
);

    logic [LAT_W-1:0] cnt_q;
    logic [LAT_W-1:0] cnt_d;

    // A new producer overrides the countdown of the previous one.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (!hold_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Register scoreboard for decode: stalls on producers that cannot yet be
// forwarded, selects forwarding stages, and squashes fetch/decode on redirects.
module scoreboard_hazard_unit
    import cpu_types_pkg::*;
#(
    parameter int NREGS     = 32,
    parameter int LAT_W     = 2,
    parameter int FWD_LIMIT = 1,
    parameter int FLUSH_CYC = 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             issue_en,
    input  regbits_t         issue_wsel,
    input  logic [LAT_W-1:0] issue_lat,
    input  regbits_t         rsel1,
    input  regbits_t         rsel2,
    input  logic             mem_wait,
    input  logic             branch_taken,
    input  logic             jump,
    output logic             hazard,
    output logic             flush,
    output logic [LAT_W-1:0] fwd1_sel,
    output logic [LAT_W-1:0] fwd2_sel,
    output logic [NREGS-1:0] busy_mask,
    output word_t            stall_count
);

    localparam logic [1:0] FLUSH_INIT = 2'(FLUSH_CYC);

    logic [LAT_W-1:0] cnt [NREGS];
    logic             issue_accept;
    logic [LAT_W-1:0] src1_cnt;
    logic [LAT_W-1:0] src2_cnt;
    logic             src1_stall;
    logic             src2_stall;

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [1:0]       flush_ctr_q;
    logic [1:0]       flush_ctr_d;
    word_t            stall_count_q;
    word_t            stall_count_d;

    assign cnt[0]       = '0;
    assign busy_mask[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREGS; gi++) begin : g_entry
            sb_entry #(
                .LAT_W (LAT_W)
            ) u_entry (
                .clk        (CLK),
                .rst_n      (nRST),
                .load_i     (issue_accept && (issue_wsel == regbits_t'(gi))),
                .load_val_i (issue_lat),
                .hold_i     (mem_wait),
                .cnt_o      (cnt[gi])
            );
            assign busy_mask[gi] = (cnt[gi] != '0);
        end
    endgenerate

    // Source lookup always sees the counters before this cycle's update, so
    // an instruction reading its own destination checks the older producer.
    always_comb begin
        src1_cnt = '0;
        src2_cnt = '0;
        if (int'(rsel1) < NREGS) begin
            src1_cnt = cnt[rsel1];
        end
        if (int'(rsel2) < NREGS) begin
            src2_cnt = cnt[rsel2];
        end
    end

    assign src1_stall = (rsel1 != '0) && (int'(src1_cnt) > FWD_LIMIT);
    assign src2_stall = (rsel2 != '0) && (int'(src2_cnt) > FWD_LIMIT);

    assign flush  = (state_q == FLUSH);
    assign hazard = (src1_stall || src2_stall) && !flush;

    assign fwd1_sel = ((rsel1 != '0) && !src1_stall) ? src1_cnt : '0;
    assign fwd2_sel = ((rsel2 != '0) && !src2_stall) ? src2_cnt : '0;

    assign issue_accept = issue_en && !hazard && !mem_wait && !flush &&
                          (issue_wsel != '0);

    // Redirects arriving while already flushing are dropped; the flush window
    // only advances on cycles where the pipeline actually moves.
    always_comb begin
        state_d     = state_q;
        flush_ctr_d = flush_ctr_q;
        case (state_q)
            RUN: begin
                if (branch_taken || jump) begin
                    state_d     = FLUSH;
                    flush_ctr_d = FLUSH_INIT;
                end
            end
            FLUSH: begin
                if (!mem_wait) begin
                    if (flush_ctr_q == 2'd1) begin
                        state_d     = RUN;
                        flush_ctr_d = '0;
                    end else begin
                        flush_ctr_d = flush_ctr_q - 2'd1;
                    end
                end
            end
            default: begin
                state_d     = RUN;
                flush_ctr_d = '0;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (hazard) begin
            stall_count_d = sat_inc(stall_count_q);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= RUN;
            flush_ctr_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            flush_ctr_q   <= flush_ctr_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule
